// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: access-size codes, FSM state
// encodings and the default byte address of data-memory word 0.
package lsu_defs;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [31:0] LSU_ADDR_BASE = 32'h1001_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_MERGE = 3'd2,
    ST_WR    = 3'd3,
    ST_ERR   = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: extracts and extends the load
// field, and merges store data into the memory word for read-modify-write.
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] merge_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel = mem_word[8*lane +: 8];
    half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];
    sext     = ~uns;
    case (size)
      SIZE_B:  load_val = {{24{sext & byte_sel[7]}}, byte_sel};
      SIZE_H:  load_val = {{16{sext & half_sel[15]}}, half_sel};
      default: load_val = mem_word;
    endcase
  end

  // Each byte lane independently picks new store data or keeps the memory byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       sel;
      logic [7:0] src;

      always_comb begin
        sel = 1'b1;
        src = store_data[8*gi +: 8];
        case (size)
          SIZE_B: begin
            sel = (lane == LANE);
            src = store_data[7:0];
          end
          SIZE_H: begin
            sel = (lane[1] == LANE[1]);
            src = store_data[8*(gi%2) +: 8];
          end
          default: ;
        endcase
      end

      assign merge_word[8*gi +: 8] = sel ? src : mem_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide synchronous data memory.
// Optional misalignment trapping is enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit
  import lsu_defs::*;
#(
  parameter logic [31:0] ADDR_BASE = LSU_ADDR_BASE,
  parameter int          MEM_AW    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              dmem_rena,
  output logic              dmem_wena,
  output logic [MEM_AW-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_t        state_reg, state_next;
  logic              we_reg, uns_reg;
  logic [1:0]        size_reg, lane_reg;
  logic [MEM_AW-1:0] waddr_reg;
  logic [31:0]       wdata_reg, rdata_reg;
  logic              done_reg;

  logic [31:0] off;
  logic [1:0]  size_in, lane_in;
  logic        unused_off_hi;
  logic [31:0] load_val, merge_word;

  assign off           = addr - ADDR_BASE;
  assign size_in       = (size == 2'b11) ? SIZE_W : size;
  assign unused_off_hi = ^off[31:MEM_AW+2];

`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned;
  logic err_reg;

  assign misaligned = ((size_in == SIZE_H) && off[0]) ||
                      ((size_in == SIZE_W) && (off[1:0] != 2'b00));
  assign lane_in    = off[1:0];
  assign err        = err_reg;
`else
  // Without trapping, misaligned halves/words are quietly aligned down.
  always_comb begin
    case (size_in)
      SIZE_H:  lane_in = {off[1], 1'b0};
      SIZE_W:  lane_in = 2'b00;
      default: lane_in = off[1:0];
    endcase
  end
  assign err = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .size       (size_reg),
    .uns        (uns_reg),
    .lane       (lane_reg),
    .mem_word   (dmem_rdata),
    .store_data (wdata_reg),
    .load_val   (load_val),
    .merge_word (merge_word)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
`ifdef LSU_ALIGN_CHECK_EN
          if (misaligned) state_next = ST_ERR;
          else
`endif
          if (we && (size_in == SIZE_W)) state_next = ST_WR;
          else                           state_next = ST_RD;
        end
      end
      ST_RD:    state_next = ST_MERGE;
      ST_MERGE: state_next = ST_IDLE;
      ST_WR:    state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= 2'b00;
      lane_reg  <= 2'b00;
      waddr_reg <= '0;
      wdata_reg <= 32'd0;
      rdata_reg <= 32'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == ST_MERGE) || (state_reg == ST_WR) ||
                   (state_reg == ST_ERR);
      if ((state_reg == ST_IDLE) && req) begin
        we_reg    <= we;
        uns_reg   <= uns;
        size_reg  <= size_in;
        lane_reg  <= lane_in;
        waddr_reg <= off[MEM_AW+1:2];
        wdata_reg <= wdata;
      end
      if ((state_reg == ST_MERGE) && !we_reg) rdata_reg <= load_val;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_reg <= 1'b0;
    else        err_reg <= (state_reg == ST_ERR);
  end
`endif

  // Enables decode from state alone so an asynchronous reset kills them at once.
  assign dmem_rena  = (state_reg == ST_RD);
  assign dmem_wena  = ((state_reg == ST_MERGE) && we_reg) || (state_reg == ST_WR);
  assign dmem_addr  = waddr_reg;
  assign dmem_wdata = merge_word;
  assign busy       = (state_reg != ST_IDLE);
  assign rdata      = rdata_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// 1024x32 data memory and a scoreboard of expected completions.
module tb_load_store_unit;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        done, err, busy, dmem_rena, dmem_wena;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic [31:0] rd;
    logic        er;
    logic        chk_rd;
  } sb_t;
  sb_t sbq[$];

  int tests = 0, fails = 0;
  int rena_cnt = 0, wena_cnt = 0;
  logic [9:0] last_waddr = '0;
  bit both_seen = 1'b0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .busy(busy), .dmem_rena(dmem_rena), .dmem_wena(dmem_wena),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  always @(posedge clk) begin
    if (dmem_wena) mem[dmem_addr] <= dmem_wdata;
    if (dmem_rena) dmem_rdata <= mem[dmem_addr];
  end

  always @(negedge clk) begin
    if (dmem_rena) rena_cnt++;
    if (dmem_wena) begin
      wena_cnt++;
      last_waddr = dmem_addr;
    end
    if (dmem_rena && dmem_wena) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input string tag, input logic w, input logic [1:0] sz,
                           input logic u, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input logic chk_rd, input int exp_lat,
                           input int exp_rena, input int exp_wena);
    int r0, w0, lat;
    bit got;
    sb_t e;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = wd; req = 1'b1;
    sbq.push_back('{exp_rd, exp_err, chk_rd});
    r0 = rena_cnt; w0 = wena_cnt;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk);
      lat++;
      #1;
      if (done === 1'b1) got = 1'b1;
    end
    chk({tag, " done"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    e = sbq.pop_front();
    if (e.chk_rd) chk({tag, " rdata"}, rdata, e.rd);
    chk({tag, " err"}, 32'(err), 32'(e.er));
    @(negedge clk);
    chk({tag, " rena cycles"}, 32'(rena_cnt - r0), 32'(exp_rena));
    chk({tag, " wena cycles"}, 32'(wena_cnt - w0), 32'(exp_wena));
    $display("[TB] %s addr=%h rdata=%h err=%0b lat=%0d", tag, a, rdata, err, lat);
  endtask

  initial begin
    sb_t e;
    int ndone, cyc, extra;
    int done_at [2];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rdata", rdata, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rena", 32'(dmem_rena), 32'd0);
    chk("reset wena", 32'(dmem_wena), 32'd0);
    rst_n = 1'b1;

    // Word store then load back
    do_access("sw w2", 1'b1, 2'b10, 1'b0, BASE + 32'h8, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1, 0, 1);
    chk("sw w2 waddr", 32'(last_waddr), 32'd2);
    chk("sw w2 mem", mem[2], 32'hDEAD_BEEF);
    do_access("lw w2", 1'b0, 2'b10, 1'b0, BASE + 32'h8, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 2, 1, 0);

    // Sub-word loads with sign/zero extension
    do_access("sw w2b", 1'b1, 2'b11, 1'b0, BASE + 32'h8, 32'h8070_F0A5, 32'd0, 1'b0, 1'b0, 1, 0, 1);
    do_access("lb l3", 1'b0, 2'b00, 1'b0, BASE + 32'hB, 32'd0, 32'hFFFF_FF80, 1'b0, 1'b1, 2, 1, 0);
    do_access("lbu l3", 1'b0, 2'b00, 1'b1, BASE + 32'hB, 32'd0, 32'h0000_0080, 1'b0, 1'b1, 2, 1, 0);
    do_access("lh l2", 1'b0, 2'b01, 1'b0, BASE + 32'hA, 32'd0, 32'hFFFF_8070, 1'b0, 1'b1, 2, 1, 0);
    do_access("lhu l0", 1'b0, 2'b01, 1'b1, BASE + 32'h8, 32'd0, 32'h0000_F0A5, 1'b0, 1'b1, 2, 1, 0);

    // Read-modify-write sub-word stores; rdata must hold the last load value
    do_access("sw w2c", 1'b1, 2'b10, 1'b0, BASE + 32'h8, 32'h1122_3344, 32'h0000_F0A5, 1'b0, 1'b1, 1, 0, 1);
    do_access("sb l1", 1'b1, 2'b00, 1'b0, BASE + 32'h9, 32'h0000_00AB, 32'h0000_F0A5, 1'b0, 1'b1, 2, 1, 1);
    chk("sb l1 mem", mem[2], 32'h1122_AB44);
    do_access("sh l2", 1'b1, 2'b01, 1'b0, BASE + 32'hA, 32'h0000_CDEF, 32'h0000_F0A5, 1'b0, 1'b1, 2, 1, 1);
    chk("sh l2 mem", mem[2], 32'hCDEF_AB44);

    // Misaligned word load
    do_access("sw w1", 1'b1, 2'b10, 1'b0, BASE + 32'h4, 32'h0BAD_F00D, 32'd0, 1'b0, 1'b0, 1, 0, 1);
`ifdef LSU_ALIGN_CHECK_EN
    do_access("lw mis", 1'b0, 2'b10, 1'b0, BASE + 32'h6, 32'd0, 32'h0000_F0A5, 1'b1, 1'b1, 1, 0, 0);
`else
    do_access("lw mis", 1'b0, 2'b10, 1'b0, BASE + 32'h6, 32'd0, 32'h0BAD_F00D, 1'b0, 1'b1, 2, 1, 0);
`endif

    // Reset during the MERGE cycle of a byte store
    do_access("sw w3", 1'b1, 2'b10, 1'b0, BASE + 32'hC, 32'h1122_3344, 32'd0, 1'b0, 1'b0, 1, 0, 1);
    @(negedge clk);
    we = 1'b1; size = 2'b00; uns = 1'b0; addr = BASE + 32'hD; wdata = 32'h0000_00AB; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-abort wena", 32'(dmem_wena), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort wena", 32'(dmem_wena), 32'd0);
    chk("abort rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort mem", mem[3], 32'h1122_3344);
    $display("[TB] reset abort mem[3]=%h busy=%0b", mem[3], busy);
    do_access("lw w3", 1'b0, 2'b10, 1'b0, BASE + 32'hC, 32'd0, 32'h1122_3344, 1'b0, 1'b1, 2, 1, 0);

    // Address wrap onto word 0
    do_access("sw wrap", 1'b1, 2'b10, 1'b0, BASE + 32'h1000, 32'hCAFE_F00D, 32'h1122_3344, 1'b0, 1'b1, 1, 0, 1);
    chk("sw wrap waddr", 32'(last_waddr), 32'd0);
    chk("sw wrap mem", mem[0], 32'hCAFE_F00D);

    // req held high: one acceptance per IDLE, second taken in the done cycle
    @(negedge clk);
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = BASE + 32'h1000; wdata = 32'd0; req = 1'b1;
    sbq.push_back('{32'hCAFE_F00D, 1'b0, 1'b1});
    sbq.push_back('{32'hCDEF_AB44, 1'b0, 1'b1});
    ndone = 0; cyc = 0;
    done_at[0] = 0; done_at[1] = 0;
    while (ndone < 2 && cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done === 1'b1) begin
        e = sbq.pop_front();
        chk("b2b rdata", rdata, e.rd);
        chk("b2b err", 32'(err), 32'(e.er));
        done_at[ndone] = cyc;
        ndone++;
        $display("[TB] b2b load %0d rdata=%h cycle=%0d", ndone, rdata, cyc);
        if (ndone == 1) addr = BASE + 32'h8;
        else req = 1'b0;
      end
    end
    req = 1'b0;
    chk("b2b done count", 32'(ndone), 32'd2);
    chk("b2b first done cycle", 32'(done_at[0]), 32'd3);
    chk("b2b second done cycle", 32'(done_at[1]), 32'd6);
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    chk("b2b extra done", 32'(extra), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);
    chk("rena/wena exclusive", 32'(both_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU's MEM stage and the word-wide synchronous data memory (1024 x 32, 1-cycle registered read, word-only write).
- Converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses.
- Sign/zero-extends loads. Sub-word stores are done as read-modify-write.
- Handshake to the CPU is req/done, so the CPU stalls while busy is high.

Parameters:
- ADDR_BASE, 32'h1001_0000, byte address mapped to word 0 of data memory.
- MEM_AW, 10, data-memory word-address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request strobe; sampled only when IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word (11 is treated as word)
- uns  in  1  loads: 1 = zero-extend, 0 = sign-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- rdata  out  32  load result, registered
- done  out  1  one-cycle completion pulse, registered
- err  out  1  valid with done; misaligned access
- busy  out  1  high when state != IDLE
- dmem_rena  out  1  data-memory read enable
- dmem_wena  out  1  data-memory write enable
- dmem_addr  out  MEM_AW  word address
- dmem_wdata  out  32  word to write
- dmem_rdata  in  32  registered memory output

Behaviour:
- Reset, asynchronous: state=IDLE; rdata=0, done=0, err=0; all request latches=0.
  - dmem_rena, dmem_wena and busy decode from state only, so they drop to 0 immediately on reset.
  - Reset mid-operation aborts the access. No write is issued after rst_n falls.
- Acceptance: in IDLE with req=1 at a rising edge, the unit latches we, size, uns, addr and wdata. req is ignored in any other state.
- Address mapping:
  - off = addr - ADDR_BASE, modulo 2^32.
  - dmem_addr = off[MEM_AW+1:2]; upper bits are discarded, so addresses wrap.
  - lane = off[1:0].
- Byte lanes are little-endian: lane 0 = bits 7:0.
- States: IDLE, RD, MERGE, WR, ERR.
- IDLE on acceptance:
  - If misaligned (half with lane[0]=1, or word with lane!=0), go to ERR.
  - Else if store word, go to WR.
  - Else go to RD.
- RD: dmem_rena=1. Next state is CAP_or_MERGE:
  - Load goes to MERGE, which is used as the capture state for loads.
  - Sub-word store goes to MERGE.
- MERGE:
  - Load: rdata <= extended lane field; done <= 1 at the edge leaving MERGE. Next state is IDLE.
  - Sub-word store: dmem_wena=1 and dmem_wdata = dmem_rdata with the selected byte/half replaced by wdata[7:0]/[15:0]. The write commits at the leaving edge, with done <= 1. Next state is IDLE.
- WR (word store): dmem_wena=1, dmem_wdata=wdata. The write commits at the leaving edge, with done <= 1. Next state is IDLE.
- ERR: no memory enable is asserted. done <= 1 and err <= 1 at the leaving edge; rdata holds. Next state is IDLE.
- Latency, counted in edges from the acceptance edge to the edge that registers done:
  - sw: 1
  - misaligned: 1
  - loads: 2
  - sb/sh: 2
- A new req may be accepted on the cycle in which done is high.
- done and err are single-cycle pulses and clear on the next edge.
- Extension:
  - byte: {24{s&b[7]}, b}
  - half: {16{s&h[15]}, h}
  - s = ~uns
  - word loads ignore uns.
- dmem_rena and dmem_wena are never high together.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: misaligned accesses take the ERR path as above.
- Undefined: there is no ERR state and err is tied 0.
  - Misaligned half/word addresses are silently aligned down: lane[0] is cleared for half, lane is cleared to 00 for word.
  - The access then proceeds normally.

Decomposition:
- Shared package/header lsu_defs holds:
  - SIZE_B/SIZE_H/SIZE_W codes
  - state encodings
  - default ADDR_BASE
- One natural combinational sub-module, lsu_lane_align:
  - inputs: size, uns, lane, memory word, store data
  - outputs: extended load value and merged store word
- The parent keeps the FSM and registers.

Test Plan:
- sw addr=0x1001_0008 wdata=0xDEADBEEF -> dmem_wena one cycle with dmem_addr=2; done one edge after acceptance; lw from same address returns rdata=0xDEADBEEF, done two edges after acceptance.
- Memory word 2 = 0x8070_F0A5:
  - lb lane3 -> 0xFFFF_FF80
  - lbu lane3 -> 0x0000_0080
  - lh lane2 -> 0xFFFF_8070
  - lhu lane0 -> 0x0000_F0A5
- Memory word 2 = 0x1122_3344:
  - sb lane1 wdata=0xAB -> 0x1122_AB44
  - then sh lane2 wdata=0xCDEF -> 0xCDEF_AB44
  - each: rena cycle, then wena cycle.
- lw addr=0x1001_0006:
  - With LSU_ALIGN_CHECK_EN: done=1, err=1 one edge after acceptance; no rena/wena; rdata unchanged.
  - Without the macro: reads word 1.
- Reset mid-operation: assert rst_n=0 during MERGE of an sb -> memory word unchanged; busy=0, done=0 immediately. After release, a new lw completes normally.
- req held high during busy plus back-to-back requests -> only one acceptance per IDLE; second request accepted in the done cycle; addr 0x1001_1000 wraps to dmem_addr=0.
